// File: rtl/board_tally.sv
// Boarding tally: counts crew, passengers and cargo during a session and
// presents the final tallies to the load stage once the hatch is sealed.
module board_tally #(
    parameter int MAX_CREW  = 4,
    parameter int MAX_PASS  = 15,
    parameter int MAX_CARGO = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       board_valid,
    input  logic [1:0] board_kind,
    output logic       board_ready,
    input  logic       seal,
    input  logic       tally_ack,
    output logic [3:0] crew_count,
    output logic [3:0] passenger_count,
    output logic [3:0] cargo_count,
    output logic       tally_valid,
    output logic       fault
);

    typedef enum logic [1:0] {IDLE, BOARDING, SEALED} state_t;

    state_t          stateReg, stateNext;
    logic [2:0][3:0] countReg, countNext;
    logic            faultReg, faultNext;
    logic [2:0]      incHit, decHit, atMax, atZero, overflow, fullNext;
    logic            accept, clearAll;

    // Counts are 4-bit, so a limit above 15 could never be reached.
    if (MAX_CREW > 15 || MAX_PASS > 15 || MAX_CARGO > 15) begin : gBadMax
        $error("board_tally: MAX_CREW, MAX_PASS and MAX_CARGO must be <= 15");
    end

    assign accept   = board_valid && (stateReg == BOARDING);
    assign clearAll = start && (stateReg == IDLE);

    // Slot 0 crew, 1 passenger, 2 cargo; kind 11 decrements the passenger slot.
    for (genvar gi = 0; gi < 3; gi++) begin : gCount
        localparam int MAXC = (gi == 0) ? MAX_CREW : (gi == 1) ? MAX_PASS : MAX_CARGO;
        localparam logic [3:0] MAXV = 4'(MAXC);

        assign incHit[gi]   = accept && (board_kind == 2'(gi));
        assign decHit[gi]   = accept && (board_kind == 2'b11) && (gi == 1);
        assign atMax[gi]    = (countReg[gi] == MAXV);
        assign atZero[gi]   = (countReg[gi] == 4'd0);
        assign overflow[gi] = (incHit[gi] && atMax[gi]) || (decHit[gi] && atZero[gi]);

        assign countNext[gi] = clearAll                  ? 4'd0 :
                               (incHit[gi] && !atMax[gi])  ? countReg[gi] + 4'd1 :
                               (decHit[gi] && !atZero[gi]) ? countReg[gi] - 4'd1 :
                                                             countReg[gi];
        assign fullNext[gi] = (countNext[gi] == MAXV);
    end

    assign faultNext = clearAll ? 1'b0 : (faultReg || (|overflow));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            countReg <= '0;
            faultReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            faultReg <= faultNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE:     if (start) stateNext = BOARDING;
            BOARDING: if (seal || (&fullNext)) stateNext = SEALED;
            SEALED:   if (tally_ack) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        board_ready = (stateReg == BOARDING);
        tally_valid = (stateReg == SEALED);
    end

    assign crew_count      = countReg[0];
    assign passenger_count = countReg[1];
    assign cargo_count     = countReg[2];
    assign fault           = faultReg;

endmodule

// File: doc/board_tally.md
BOARD_TALLY -- requirements
Module: board_tally

Interface
REQ-001 SHALL have parameter MAX_CREW, default 4, crew count at which the crew tally saturates.
REQ-002 SHALL have parameter MAX_PASS, default 15, passenger count at which the passenger tally saturates.
REQ-003 SHALL have parameter MAX_CARGO, default 15, cargo count at which the cargo tally saturates.
REQ-004 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  pulse that opens a boarding session.
REQ-007 SHALL have port board_valid  input  1  a boarding event is presented.
REQ-008 SHALL have port board_kind  input  2  event kind: 00 crew, 01 passenger, 10 cargo, 11 passenger disembark.
REQ-009 SHALL have port board_ready  output  1  the block can accept a boarding event.
REQ-010 SHALL have port seal  input  1  request to close the hatch.
REQ-011 SHALL have port tally_ack  input  1  downstream load stage has consumed the tallies.
REQ-012 SHALL have port crew_count  output  4  crew tally.
REQ-013 SHALL have port passenger_count  output  4  passenger tally.
REQ-014 SHALL have port cargo_count  output  4  cargo tally.
REQ-015 SHALL have port tally_valid  output  1  the tallies are final and stable for the load stage.
REQ-016 SHALL have port fault  output  1  sticky overflow or underflow flag for the current session.

Function
REQ-017 SHALL implement a three-state FSM with states IDLE, BOARDING and SEALED.
REQ-018 IDLE SHALL move to BOARDING on start=1, and SHALL clear all three counts and fault on that same edge.
REQ-019 board_ready SHALL be 1 only in BOARDING, driven as a combinational decode of the state register.
REQ-020 An event SHALL be accepted on an edge where board_valid=1 and board_ready=1.
REQ-021 An accepted kind 00/01/10 SHALL increment the selected count by 1, one cycle latency, and the new value SHALL be visible the cycle after acceptance.
REQ-022 An accepted increment to a count already at its MAX SHALL leave the count unchanged and set fault.
REQ-023 An accepted kind 11 SHALL decrement passenger_count by 1, and at 0 SHALL leave the count at 0 and set fault.
REQ-024 Once set, fault SHALL hold until the next start accepted from IDLE, or until reset.
REQ-025 BOARDING SHALL move to SEALED on seal=1.
REQ-026 BOARDING SHALL also move to SEALED automatically when, after the current update, crew=MAX_CREW, passenger=MAX_PASS and cargo=MAX_CARGO.
REQ-027 If seal=1 and an event is accepted on the same edge, the event SHALL be applied and the FSM SHALL enter SEALED.
REQ-028 start SHALL be ignored in BOARDING and SEALED.
REQ-029 board_valid SHALL be ignored outside BOARDING, and counts SHALL not change there.
REQ-030 In SEALED, tally_valid SHALL be 1 and all counts SHALL be held stable.
REQ-031 SEALED SHALL move to IDLE on tally_ack=1.
REQ-032 Counts SHALL remain readable in IDLE until the next start.
REQ-033 tally_ack SHALL be ignored outside SEALED.
REQ-034 All arithmetic SHALL be 4-bit unsigned and SHALL never wrap.
REQ-035 The design SHALL require MAX_* ≤ 15; the implementation SHALL flag a larger value at elaboration.

Reset
REQ-036 While rst_n=0, the block SHALL force state=IDLE, all counts=0, fault=0, tally_valid=0 and board_ready=0, immediately and independent of clk.
REQ-037 Reset asserted mid-BOARDING or mid-SEALED SHALL discard the session.
REQ-038 After rst_n deasserts, the block SHALL require a new start to begin a session.

Verification
REQ-039 Reset: assert rst_n=0 mid-BOARDING with counts 3/7/2 -> all outputs 0 within the same cycle, and board_ready=0 after release.
REQ-040 Normal session: start; 4 crew, 15 passenger, 15 cargo events -> auto-seal, tally_valid=1, counts 4/15/15, fault=0; tally_ack -> IDLE, counts retained.
REQ-041 Saturation: 5 crew events -> crew_count=4 and fault=1; a following start -> fault=0 and crew_count=0.
REQ-042 Underflow: kind 11 with passenger_count=0 -> count stays 0 and fault=1.
REQ-043 Simultaneous: seal=1 together with an accepted cargo event at cargo=6 -> cargo=7 and the FSM in SEALED the next cycle.
REQ-044 Ignored inputs: board_valid in IDLE, start in SEALED, tally_ack in BOARDING -> no state or count change.
